// File: rtl/aftab_machine_timer_if.sv
// AFTAB 8-bit memory bus as seen by a byte-wide peripheral: level requests from the core,
// one-cycle ready strobe and OR-able read data back.
interface aftab_machine_timer_if;
   logic        readmem;
   logic        writemem;
   logic [31:0] addressBus;
   logic [7:0]  dataBusIn;
   logic [7:0]  dataBusOut;
   logic        memDataReady;

   modport master (
      output readmem, writemem, addressBus, dataBusIn,
      input  dataBusOut, memDataReady
   );

   modport slave (
      input  readmem, writemem, addressBus, dataBusIn,
      output dataBusOut, memDataReady
   );
endinterface

// File: rtl/aftab_machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) on the AFTAB byte bus; ready strobes READY_LATENCY+1 cycles after a hit.
// No backpressure: a held request is acknowledged once, then parked in DONE until released.
module aftab_machine_timer #(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_3000,
   parameter int          READY_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   aftab_machine_timer_if.slave bus,
   output logic                 machineTimerInterrupt
);

   localparam int CW = (READY_LATENCY > 1) ? $clog2(READY_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(READY_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [4:0]    r_offset;
   logic          r_is_wr;
   logic [7:0]    r_wdat;
   logic [CW-1:0] r_cnt;

   logic [63:0]   r_mtime;
   logic [63:0]   r_mtimecmp;
   logic          r_en;
   logic [7:0]    r_prescale;
   logic [7:0]    r_presc_cnt;
   logic          r_irq;

   logic          w_hit;
   logic          w_ack;
   logic          w_wr;
   logic          w_tick;
   logic [7:0]    w_rdat;
   logic [63:0]   w_mtime_wr;

   assign w_hit  = (bus.readmem | bus.writemem) & (bus.addressBus[31:5] == BASE_ADDR[31:5]);
   assign w_ack  = (r_state == S_ACK);
   assign w_wr   = w_ack & r_is_wr;
   assign w_tick = (r_presc_cnt == r_prescale);

   assign bus.memDataReady    = w_ack;
   assign bus.dataBusOut      = (w_ack & ~r_is_wr) ? w_rdat : 8'h00;
   assign machineTimerInterrupt = r_irq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_hit) w_next_state = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_next_state = S_ACK;
         S_ACK:   w_next_state = S_DONE;
         S_DONE:  if (!bus.readmem && !bus.writemem) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Both strobes high is a write, so is_wr follows writemem alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_offset <= '0;
         r_is_wr  <= 1'b0;
         r_wdat   <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_IDLE && w_hit) begin
         r_offset <= bus.addressBus[4:0];
         r_is_wr  <= bus.writemem;
         r_wdat   <= bus.dataBusIn;
         r_cnt    <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_comb begin
      w_rdat = 8'h00;
      case (r_offset[4:3])
         2'd0: w_rdat = r_mtime[{r_offset[2:0], 3'b000} +: 8];
         2'd1: w_rdat = r_mtimecmp[{r_offset[2:0], 3'b000} +: 8];
         default: begin
            if (r_offset == 5'h10) w_rdat = {7'd0, r_en};
            else if (r_offset == 5'h11) w_rdat = r_prescale;
         end
      endcase
   end

   always_comb begin
      w_mtime_wr = r_mtime;
      w_mtime_wr[{r_offset[2:0], 3'b000} +: 8] = r_wdat;
   end

   // A bus write to mtime replaces the whole word, so a coincident tick is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtime     <= '0;
         r_mtimecmp  <= '1;
         r_en        <= 1'b0;
         r_prescale  <= '0;
         r_presc_cnt <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_irq <= r_en & (r_mtime >= r_mtimecmp);
         if (r_en) begin
            if (w_tick) begin
               r_presc_cnt <= '0;
               r_mtime     <= r_mtime + 64'd1;
            end else begin
               r_presc_cnt <= r_presc_cnt + 8'd1;
            end
         end
         if (w_wr) begin
            if (r_offset[4:3] == 2'd0) begin
               r_mtime <= w_mtime_wr;
            end else if (r_offset[4:3] == 2'd1) begin
               r_mtimecmp[{r_offset[2:0], 3'b000} +: 8] <= r_wdat;
            end else if (r_offset == 5'h10) begin
               r_en <= r_wdat[0];
            end else if (r_offset == 5'h11) begin
               r_prescale  <= r_wdat;
               r_presc_cnt <= '0;
            end
         end
      end
   end

endmodule
